addsub_acc_sequencer: RTL and testbench

- Command-driven accumulator stage that wraps the existing N-bit adder/subtractor.
- Accepts ADD/SUB/LOAD/CLEAR commands over a valid/ready handshake and drives the adder operand ports from registers.
- Captures the adder result into an accumulator, then presents the result with signed-overflow and zero flags on a valid/ready response port.
- Adds the overflow detection the adder itself does not provide.

---
 rtl/addsub_acc_sequencer.sv | 145 ++++++++++++++
 tb/tb_addsub_acc_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_acc_sequencer.sv
// addsub_acc_sequencer: command-driven accumulator around an external
// combinational adder/subtractor. Accepts ADD/SUB/LOAD/CLEAR commands,
// drives the adder operands from registers, captures the result and
// returns it with signed-overflow and zero flags over a valid/ready port.
module addsub_acc_sequencer #(
    parameter int NBIT = 10,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_op_i,
    input  logic [NBIT-1:0] cmd_data_i,
    output logic [NBIT-1:0] add_a_o,
    output logic [NBIT-1:0] add_b_o,
    output logic            add_sub_o,
    input  logic [NBIT-1:0] add_result_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [NBIT-1:0] rsp_data_o,
    output logic            rsp_ovf_o,
    output logic            rsp_zero_o,
    output logic [CNTW-1:0] cmd_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t          r_state;
    state_t          w_next;
    logic [NBIT-1:0] r_acc;
    logic [NBIT-1:0] r_op_b;
    logic            r_sub;
    logic            r_ovf;
    logic            r_zero;
    logic [CNTW-1:0] r_count;

    logic            w_accept;
    logic            w_is_arith;
    logic            w_sign_a;
    logic            w_sign_b;
    logic            w_sign_r;
    logic            w_ovf;

    assign w_accept   = (r_state == S_IDLE) && cmd_valid_i;
    assign w_is_arith = (cmd_op_i == OP_ADD) || (cmd_op_i == OP_SUB);

    // Signed overflow from operand/result sign bits; the adder has no flag.
    assign w_sign_a = r_acc[NBIT-1];
    assign w_sign_b = r_op_b[NBIT-1];
    assign w_sign_r = add_result_i[NBIT-1];
    assign w_ovf    = r_sub ? ((w_sign_a != w_sign_b) && (w_sign_r != w_sign_a))
                            : ((w_sign_a == w_sign_b) && (w_sign_r != w_sign_a));

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake outputs, all decoded from registered state.
    always_comb begin
        // NOTE: defaults first so every path assigns every output (no latches).
        w_next      = r_state;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = !rst_i;
                if (cmd_valid_i) begin
                    w_next = w_is_arith ? S_EXEC : S_RESP;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: latch command operands on accept, capture adder result in EXEC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc   <= '0;
            r_op_b  <= '0;
            r_sub   <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b1;
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= r_count + CNTW'(1);
            case (cmd_op_i)
                OP_ADD, OP_SUB: begin
                    r_op_b <= cmd_data_i;
                    r_sub  <= (cmd_op_i == OP_SUB);
                end
                OP_LOAD: begin
                    r_acc  <= cmd_data_i;
                    r_ovf  <= 1'b0;
                    r_zero <= (cmd_data_i == '0);
                end
                default: begin
                    r_acc  <= '0;
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b1;
                end
            endcase
        end else if (r_state == S_EXEC) begin
            r_acc  <= add_result_i;
            r_ovf  <= w_ovf;
            r_zero <= (add_result_i == '0);
        end
    end

    assign add_a_o     = r_acc;
    assign add_b_o     = r_op_b;
    assign add_sub_o   = r_sub;
    assign rsp_data_o  = r_acc;
    assign rsp_ovf_o   = r_ovf;
    assign rsp_zero_o  = r_zero;
    assign cmd_count_o = r_count;

endmodule

// File: tb/tb_addsub_acc_sequencer.sv
// tb_addsub_acc_sequencer: directed, table-driven bench for the accumulator
// sequencer with a behavioural adder model (NBIT=8, CNTW=4).
module tb_addsub_acc_sequencer;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef struct {
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic       exp_ovf;
        logic       exp_zero;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_sub;
    logic [7:0] add_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_ovf;
    logic       rsp_zero;
    logic [3:0] cmd_count;

    int         n_tests;
    int         n_fail;
    logic [3:0] exp_count;
    logic [7:0] exp_acc;
    vec_t       vecs [15];

    addsub_acc_sequencer #(.NBIT(8), .CNTW(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_data_i   (cmd_data),
        .add_a_o      (add_a),
        .add_b_o      (add_b),
        .add_sub_o    (add_sub),
        .add_result_i (add_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_ovf_o    (rsp_ovf),
        .rsp_zero_o   (rsp_zero),
        .cmd_count_o  (cmd_count)
    );

    // External combinational adder/subtractor.
    assign add_result = add_sub ? (add_a - add_b) : (add_a + add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command with rsp_ready held high and check the full response.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] ed,
                           input logic eo, input logic ez, input string tag);
        int  n;
        bit  got;
        bit  arith;
        arith = (op == OP_ADD) || (op == OP_SUB);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_count = exp_count + 4'd1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                got = 1'b1;
            end else if (n == 1 && arith) begin
                check({tag, " add_a"}, 32'(add_a), 32'(exp_acc));
                check({tag, " add_b"}, 32'(add_b), 32'(d));
                check({tag, " add_sub"}, 32'(add_sub), 32'(op == OP_SUB));
            end
        end
        check({tag, " latency"}, 32'(n), arith ? 32'd2 : 32'd1);
        check({tag, " data"}, 32'(rsp_data), 32'(ed));
        check({tag, " ovf"}, 32'(rsp_ovf), 32'(eo));
        check({tag, " zero"}, 32'(rsp_zero), 32'(ez));
        check({tag, " count"}, 32'(cmd_count), 32'(exp_count));
        exp_acc = ed;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_count = 4'd0;
        exp_acc   = 8'h00;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_ADD;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;

        vecs[0]  = '{OP_LOAD,  8'h05, 8'h05, 1'b0, 1'b0};
        vecs[1]  = '{OP_LOAD,  8'h7F, 8'h7F, 1'b0, 1'b0};
        vecs[2]  = '{OP_ADD,   8'h01, 8'h80, 1'b1, 1'b0};
        vecs[3]  = '{OP_LOAD,  8'h80, 8'h80, 1'b0, 1'b0};
        vecs[4]  = '{OP_SUB,   8'h01, 8'h7F, 1'b1, 1'b0};
        vecs[5]  = '{OP_LOAD,  8'h03, 8'h03, 1'b0, 1'b0};
        vecs[6]  = '{OP_SUB,   8'h03, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{OP_ADD,   8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[8]  = '{OP_SUB,   8'h7F, 8'h80, 1'b0, 1'b0};
        vecs[9]  = '{OP_SUB,   8'h01, 8'h7F, 1'b1, 1'b0};
        vecs[10] = '{OP_ADD,   8'h80, 8'hFF, 1'b0, 1'b0};
        vecs[11] = '{OP_ADD,   8'h81, 8'h80, 1'b0, 1'b0};
        vecs[12] = '{OP_CLEAR, 8'h5A, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{OP_ADD,   8'h80, 8'h80, 1'b0, 1'b0};
        vecs[14] = '{OP_ADD,   8'h80, 8'h00, 1'b1, 1'b1};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data", 32'(rsp_data), 32'd0);
        check("rst rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("rst rsp_zero", 32'(rsp_zero), 32'd1);
        check("rst count", 32'(cmd_count), 32'd0);
        check("rst add_b", 32'(add_b), 32'd0);
        check("rst add_sub", 32'(add_sub), 32'd0);
        check("rst idle ready", 32'(cmd_ready), 32'd1);

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 15; i++) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].exp_data,
                    vecs[i].exp_ovf, vecs[i].exp_zero, $sformatf("vec%0d", i));
        end

        // Response back-pressure with a queued command held on the input.
        run_cmd(OP_LOAD, 8'h10, 8'h10, 1'b0, 1'b0, "stall_load");
        @(negedge clk);
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 8'h20;
        check("stall accept ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        exp_count = exp_count + 4'd1;
        cmd_data  = 8'h01;
        @(negedge clk);
        check("stall exec ready", 32'(cmd_ready), 32'd0);
        check("stall exec valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("stall%0d data", i), 32'(rsp_data), 32'h30);
            check($sformatf("stall%0d ovf", i), 32'(rsp_ovf), 32'd0);
            check($sformatf("stall%0d ready", i), 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        check("stall count held", 32'(cmd_count), 32'(exp_count));
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("stall post valid", 32'(rsp_valid), 32'd0);
        check("stall post ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        exp_count = exp_count + 4'd1;
        @(negedge clk);
        check("stall next count", 32'(cmd_count), 32'(exp_count));
        check("stall next add_a", 32'(add_a), 32'h30);
        check("stall next add_b", 32'(add_b), 32'h01);
        @(negedge clk);
        check("stall next valid", 32'(rsp_valid), 32'd1);
        check("stall next data", 32'(rsp_data), 32'h31);

        // Reset during EXEC discards the command.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        cmd_data  = 8'h05;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("exec_rst ready low", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        exp_count = 4'd0;
        exp_acc   = 8'h00;
        @(negedge clk);
        check("exec_rst acc", 32'(add_a), 32'd0);
        check("exec_rst count", 32'(cmd_count), 32'd0);
        check("exec_rst valid", 32'(rsp_valid), 32'd0);
        check("exec_rst ready", 32'(cmd_ready), 32'd1);
        check("exec_rst zero", 32'(rsp_zero), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("exec_rst quiet%0d", i), 32'(rsp_valid), 32'd0);
        end

        // Counter wrap: 17 CLEARs take the 4-bit count 15 -> 0 -> 1.
        for (int i = 0; i < 17; i++) begin
            run_cmd(OP_CLEAR, 8'(i), 8'h00, 1'b0, 1'b1, $sformatf("clr%0d", i));
        end
        check("wrap final count", 32'(cmd_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
